// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: word/PC widths, reset PC default,
// NOP encoding and the {pc, ins} entry carried by the fetch queue.
package cpu_pkg;
  localparam int WORD_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0]   DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] NOP_INS          = 32'h0000_0000;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [WORD_W-1:0] ins;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Parameterised synchronous FIFO with a clear input.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clr             synchronous flush; overrides push and pop this cycle
//   push, push_data write one entry (ignored when full)
//   pop             drop the head entry (ignored when empty)
//   head            current head entry (storage contents, valid when count!=0)
//   count           number of entries held, 0..DEPTH
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Explicit wrap so non-power-of-two depths (e.g. MAX_OUT=3) also work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + AW'(1'b1);
    end
  endfunction

  assign do_push = push && (count_q != CW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next-state for pointers, occupancy and storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1'b1);
        2'b01:   count_d = count_q - CW'(1'b1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers; storage is cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end
endmodule

// File: rtl/fetch_queue_checker.sv
// Protocol/consistency checks for fetch_queue (simulation assertions).
// Ports:
//   clk, rst     clock and reset of the checked block
//   imem_rvalid  response strobe from instruction memory
//   outstanding  granted-but-unanswered request count
//   drop_cnt     responses still to be discarded after a redirect
//   tag_count    occupancy of the PC-tag FIFO
module fetch_queue_checker #(
  parameter int OW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rvalid,
  input logic [OW-1:0] outstanding,
  input logic [OW-1:0] drop_cnt,
  input logic [OW-1:0] tag_count
);
  // A response with nothing outstanding is a memory protocol violation.
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
    !(imem_rvalid && (outstanding == '0)));

  // Every kept in-flight request owns exactly one PC tag.
  a_tag_balance: assert property (@(posedge clk) disable iff (rst)
    tag_count == (outstanding - drop_cnt));
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues word-addressed requests to a
// variable-latency imem, buffers returned words with their PCs and hands
// {pc, ins} to execute over valid/ready. A redirect flushes the queue and
// discards responses still in flight.
// Optional build macro FETCH_BYPASS_EN: when the queue is empty, a kept
// response that execute accepts the same cycle is forwarded combinationally.
// Ports:
//   clk, rstd                 clock, asynchronous active-high reset
//   imem_req/addr/gnt         request handshake (addr in PC units)
//   imem_rvalid/rdata         in-order responses
//   ins_valid/ins/pc/ins_ready  head entry handshake to execute
//   redirect, redirect_pc     flush and restart fetch at redirect_pc
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter int               MAX_OUT  = 2,
  parameter logic [PC_W-1:0]  RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rstd,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic              ins_valid,
  output logic [WORD_W-1:0] ins,
  output logic [PC_W-1:0]   pc,
  input  logic              ins_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc
);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]   outstanding_q, outstanding_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;

  logic            grant, rsp_ok, drop_now, keep, bypass_fire;
  logic            q_valid, q_push, q_pop;
  logic [CW-1:0]   q_count;
  logic [OW-1:0]   tag_count;
  logic [PC_W-1:0] tag_head;
  fetch_entry_t    q_in, q_head;

  // Credit check: queued plus in-flight words never exceed DEPTH.
  assign imem_req  = !rstd && !redirect && (outstanding_q < OW'(MAX_OUT)) &&
                     ((32'(q_count) + 32'(outstanding_q)) < 32'(DEPTH));
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // Orphan responses (nothing outstanding) are ignored entirely.
  assign rsp_ok   = imem_rvalid && (outstanding_q != '0);
  assign drop_now = rsp_ok && (drop_cnt_q != '0);
  assign keep     = rsp_ok && (drop_cnt_q == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_fire = keep && !q_valid && ins_ready && !redirect;
`else
  assign bypass_fire = 1'b0;
`endif

  assign q_valid = (q_count != '0);
  assign q_in    = '{pc: tag_head, ins: imem_rdata};
  assign q_push  = keep && !redirect && !bypass_fire;
  assign q_pop   = q_valid && ins_ready && !redirect;

  fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rstd),
    .clr       (redirect),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  // PC tags are written at grant and consumed by kept responses only.
  fetch_fifo #(.WIDTH(PC_W), .DEPTH(MAX_OUT)) u_tags (
    .clk       (clk),
    .rst       (rstd),
    .clr       (redirect),
    .push      (grant),
    .push_data (fetch_pc_q),
    .pop       (keep),
    .head      (tag_head),
    .count     (tag_count)
  );

  // Head presentation, with optional same-cycle forwarding.
  always_comb begin
    ins_valid = q_valid;
    ins       = q_head.ins;
    pc        = q_head.pc;
    if (bypass_fire) begin
      ins_valid = 1'b1;
      ins       = imem_rdata;
      pc        = tag_head;
    end else begin
      ins_valid = q_valid;
    end
  end

  // Fetch PC, in-flight count and drop count next-state.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    case ({grant, rsp_ok})
      2'b10:   outstanding_d = outstanding_q + OW'(1'b1);
      2'b01:   outstanding_d = outstanding_q - OW'(1'b1);
      default: outstanding_d = outstanding_q;
    endcase
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + PC_W'(1'b1);
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (drop_now) begin
        drop_cnt_d = drop_cnt_q - OW'(1'b1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  fetch_queue_checker #(.OW(OW)) u_chk (
    .clk         (clk),
    .rst         (rstd),
    .imem_rvalid (imem_rvalid),
    .outstanding (outstanding_q),
    .drop_cnt    (drop_cnt_q),
    .tag_count   (tag_count)
  );
endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue: an in-order imem model with
// configurable latency returns rdata = addr + 0x100; consumed {pc, ins}
// pairs are logged and compared with hand-derived sequences.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rstd = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] pc;
  logic        ins_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int lat = 1;
  int first_valid = -1;
  int n_grant = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] got_pc[$];
  logic [31:0] got_ins[$];
  logic        hold_chk = 1'b0;
  logic [31:0] hold_addr = 32'h0;

  fetch_queue #(.DEPTH(4), .MAX_OUT(2), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rstd        (rstd),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .pc          (pc),
    .ins_ready   (ins_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with this cycle's inputs set; returns at next posedge+1.
  task automatic tick();
    #1;
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      n_grant++;
    end
    if (ins_valid && ins_ready && !redirect) begin
      got_pc.push_back(pc);
      got_ins.push_back(ins);
    end
    if (ins_valid && first_valid < 0) first_valid = cyc;
    hold_chk  = imem_req && !imem_gnt && !redirect;
    hold_addr = imem_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend_addr[0] + 32'h100;
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] start, input int n);
    check_eq({tag, "_len_ok"}, 32'(got_pc.size() >= n), 32'd1);
    for (int k = 0; k < n && k < got_pc.size(); k++) begin
      check_eq($sformatf("%s_pc%0d", tag, k), got_pc[k], start + 32'(k));
      check_eq($sformatf("%s_ins%0d", tag, k), got_ins[k], start + 32'(k) + 32'h100);
    end
  endtask

  initial begin
    int bad;
    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_valid", 32'(ins_valid), 32'd0);
    check_eq("rst_ins", ins, 32'h0);
    check_eq("rst_pc", pc, 32'h0);

    // Streaming: gnt=1, latency 1, ready=1
    rstd = 1'b0; imem_gnt = 1'b1; ins_ready = 1'b1; lat = 1; cyc = 0;
    for (int i = 0; i < 6; i++) tick();
    check_eq("first_valid_cyc", 32'(first_valid), 32'd2);
    check_stream("stream", 32'h0, 4);

    // Back-pressure: queue fills to DEPTH
    ins_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    #1;
    check_eq("full_req", 32'(imem_req), 32'd0);
    check_eq("full_valid", 32'(ins_valid), 32'd1);
    check_eq("full_head", pc, 32'h4);
    got_pc.delete(); got_ins.delete();
    imem_gnt = 1'b0; ins_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_eq("drain_cnt", 32'(got_pc.size()), 32'd4);
    check_stream("drain", 32'h4, 4);
    check_eq("drain_empty", 32'(ins_valid), 32'd0);
    check_eq("drain_addr", imem_addr, 32'h8);

    // Latency 3 with toggling grant
    got_pc.delete(); got_ins.delete(); n_grant = 0; lat = 3;
    for (int i = 0; i < 24; i++) begin
      imem_gnt = (i % 2 == 0);
      tick();
      if (hold_chk) check_eq("addr_hold", imem_addr, hold_addr);
      check_eq("max_out", 32'((pend_addr.size() + 32'(imem_rvalid)) <= 2), 32'd1);
    end
    imem_gnt = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("toggle_no_loss", 32'(got_pc.size()), 32'(n_grant));
    check_stream("toggle", 32'h8, got_pc.size());

    // Redirect with two requests (5, 6) in flight
    redirect = 1'b1; redirect_pc = 32'h5;
    #1;
    check_eq("redir_req0", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0; imem_gnt = 1'b1;
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    #1;
    check_eq("redir_req1", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0; lat = 1; ins_ready = 1'b1;
    got_pc.delete(); got_ins.delete();
    #1;
    check_eq("redir_addr", imem_addr, 32'h40);
    for (int i = 0; i < 10; i++) tick();
    check_stream("redir", 32'h40, 4);
    bad = 0;
    foreach (got_pc[k]) if (got_pc[k] == 32'h5 || got_pc[k] == 32'h6) bad++;
    check_eq("no_stale", 32'(bad), 32'd0);

    // Redirect coinciding with rvalid, dequeue and grant
    redirect = 1'b1; redirect_pc = 32'h80;
    #1;
    check_eq("coinc_valid", 32'(ins_valid), 32'd1);
    check_eq("coinc_req", 32'(imem_req), 32'd0);
    tick();
    redirect = 1'b0;
    got_pc.delete(); got_ins.delete();
    #1;
    check_eq("coinc_empty", 32'(ins_valid), 32'd0);
    check_eq("coinc_addr", imem_addr, 32'h80);
    check_eq("coinc_req_next", 32'(imem_req), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check_stream("coinc", 32'h80, 3);

    // Asynchronous reset with entries queued
    ins_ready = 1'b0;
    tick();
    tick();
    #1;
    check_eq("pre_rst_valid", 32'(ins_valid), 32'd1);
    check_eq("pre_rst_head", pc, 32'h84);
    rstd = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pend_addr.delete(); pend_due.delete();
    #1;
    check_eq("arst_valid", 32'(ins_valid), 32'd0);
    check_eq("arst_req", 32'(imem_req), 32'd0);
    check_eq("arst_addr", imem_addr, 32'h0);
    check_eq("arst_pc", pc, 32'h0);
    @(posedge clk);
    #1;
    rstd = 1'b0; ins_ready = 1'b1; imem_gnt = 1'b1; lat = 1; cyc = 0; first_valid = -1;
    got_pc.delete(); got_ins.delete();
    for (int i = 0; i < 6; i++) tick();
    check_eq("restart_first_valid", 32'(first_valid), 32'd2);
    check_stream("restart", 32'h0, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end that sits directly upstream of the execute stage.
- Issues word-addressed fetch requests to a variable-latency instruction memory (address req/gnt; in-order response rvalid) and buffers the returned words with their PCs in a small queue.
- Presents {pc, ins} to execute with a valid/ready handshake.
- On a taken branch or jump, execute's redirect flushes the queue and discards in-flight responses.

Parameters:
- DEPTH, 4, queue entries; power of two, ≥2.
- MAX_OUT, 2, maximum outstanding imem requests; 1..DEPTH.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstd  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word address of the request (PC units; +1 per instruction).
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response valid; responses arrive in request order, at least 1 cycle after gnt.
- imem_rdata  in  32  instruction word.
- ins_valid  out  1  head entry valid.
- ins  out  32  head instruction.
- pc  out  32  PC of head instruction.
- ins_ready  in  1  execute consumes head this cycle.
- redirect  in  1  taken branch/jump/jr; flush.
- redirect_pc  in  32  new fetch PC.

Behaviour:
Reset (rstd=1, asynchronous):
- Queue empty; fetch_pc=RESET_PC; outstanding=0; drop_cnt=0.
- Outputs: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, pc=0.

Credit rule and request issue:
- imem_req = !redirect && outstanding<MAX_OUT && (count+outstanding)<DEPTH.
- This credit check guarantees the queue never overflows; no response back-pressure exists.
- imem_addr = fetch_pc. On imem_req && imem_gnt: fetch_pc += 1 (32-bit wrap) and outstanding += 1.
- imem_req and imem_addr must stay stable until granted, unless a redirect occurs.

Response handling:
- When imem_rvalid: outstanding -= 1.
- If drop_cnt>0: drop_cnt -= 1 and the word is discarded.
- Otherwise enqueue {pc_tag, rdata}. pc_tag comes from an internal PC-tag FIFO of MAX_OUT entries, written at grant.

Output and latency:
- ins_valid = (count!=0); ins/pc come from the queue head.
- Dequeue on ins_valid && ins_ready.
- Enqueue and dequeue in the same cycle keep count unchanged.
- Response-to-ins_valid latency is 1 cycle.

Redirect (highest priority):
- In the cycle redirect=1: the queue is cleared, any same-cycle dequeue is ignored, and any same-cycle non-dropped response is discarded.
- fetch_pc <= redirect_pc.
- drop_cnt <= outstanding minus any response arriving that cycle (the post-update outstanding). The PC-tag FIFO is flushed accordingly.
- imem_req=0 in the redirect cycle. The first request to redirect_pc is issued the next cycle.
- Back-to-back redirects: the last one wins. Each recomputes drop_cnt from the current outstanding.
- While drop_cnt>0, new requests may still issue. Their responses follow the dropped ones in order and are kept.

Error case:
- imem_rvalid with outstanding==0 is a protocol error; it is ignored and flagged by a simulation assertion.

Full/empty:
- count==DEPTH forces imem_req=0. count==0 forces ins_valid=0.

Optional Feature:
- Macro FETCH_BYPASS_EN.
- Defined: when the queue is empty, a non-dropped response with ins_ready=1 and no redirect is forwarded combinationally. ins_valid=1, ins=imem_rdata, pc=tag in the same cycle, with no enqueue (0-cycle latency).
- Not defined: responses always enqueue first (1-cycle latency). ins/pc are registered-path only.

Decomposition:
- Shared package cpu_pkg holds:
  - WORD_W=32
  - PC_W=32
  - RESET_PC default
  - NOP_INS=32'h00000000
  - typedef fetch_entry_t {pc, ins}
- One natural sub-module: fetch_fifo, a parameterised synchronous FIFO with a clear input. It is instantiated twice: the DEPTH-entry queue of fetch_entry_t and the MAX_OUT-entry PC-tag FIFO.

Test Plan:
- Reset, imem_gnt tied 1, imem_rvalid one cycle after each gnt with rdata=addr+32'h100, ins_ready=1 -> pc sequence 0,1,2,3 with ins 0x100,0x101,0x102,0x103; ins_valid first high 2 cycles after reset release.
- ins_ready=0 for 10 cycles -> exactly DEPTH=4 entries held, imem_req=0 once count+outstanding=4; on release, PCs 0..3 drain in order with no loss.
- Two requests outstanding (addr 5,6), redirect=1 with redirect_pc=0x40 -> both responses discarded; next ins_valid shows pc=0x40; no pc 5/6 ever valid.
- Redirect in the same cycle as rvalid, ins_ready and gnt -> queue empty next cycle, fetch_pc=redirect_pc, drop_cnt equals outstanding after that cycle's updates.
- imem latency 3 cycles with gnt toggling 1,0,1 -> imem_addr held stable while ungranted; no more than MAX_OUT=2 outstanding; ordering preserved.
- Assert rstd mid-stream with 3 entries queued -> ins_valid=0, imem_req=0 immediately (async); after release, fetch restarts at RESET_PC; late responses are flagged and ignored.
